// File: rtl/partial_energy_acc.sv
// rtl/partial_energy_acc.sv - pipelined Ising energy accumulator over a streamed coupling matrix
//
// Purpose: runs one pass over DATASPIN coupling rows, PARALLELISM rows per accepted
// beat. It returns sum_r sigma_r * (sum_{j!=r} sigma_j*J_rj + h_r*scale) for the spin
// vector and bias scale that were latched at start.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   start_i, spin_i, hscaling_i        pass start (IDLE only), spin vector, bias scale
//   weight_valid_i / weight_ready_o    beat handshake
//   weight_i, hbias_i                  per-lane coupling rows and biases
//   energy_valid_o / energy_ready_i    result handshake
//   energy_o, overflow_o               total energy, sticky signed overflow
//   busy_o                             high outside IDLE
module partial_energy_acc #(
  parameter int BITJ             = 4,
  parameter int BITH             = 4,
  parameter int SCALING_BIT      = 5,
  parameter int DATASPIN         = 256,
  parameter int PARALLELISM      = 4,
  parameter int ENERGY_TOTAL_BIT = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [DATASPIN-1:0]                  spin_i,
  input  logic [SCALING_BIT-1:0]               hscaling_i,
  input  logic                                 weight_valid_i,
  output logic                                 weight_ready_o,
  input  logic [PARALLELISM*DATASPIN*BITJ-1:0] weight_i,
  input  logic [PARALLELISM*BITH-1:0]          hbias_i,
  output logic                                 energy_valid_o,
  input  logic                                 energy_ready_i,
  output logic [ENERGY_TOTAL_BIT-1:0]          energy_o,
  output logic                                 busy_o,
  output logic                                 overflow_o
);

  localparam int MULTBIT = BITH + SCALING_BIT - 1;
  // One guard bit so that negating the most negative coupling/bias is exact.
  localparam int TERMW   = ((BITJ > MULTBIT) ? BITJ : MULTBIT) + 1;
  localparam int LANEW   = TERMW + $clog2(DATASPIN);
  // Wide enough to hold the exact sum of accumulator and one lane value.
  localparam int SUMW    = ((ENERGY_TOTAL_BIT > LANEW) ? ENERGY_TOTAL_BIT : LANEW) + 1;
  localparam int IDXW    = $clog2(DATASPIN);
  localparam int CNTW    = $clog2(DATASPIN) + 1;
  localparam int HIW     = SUMW - ENERGY_TOTAL_BIT + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DATASPIN - PARALLELISM);
  localparam logic [CNTW-1:0] STEP     = CNTW'(PARALLELISM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [DATASPIN-1:0]                 spin_q;
  logic [SCALING_BIT-1:0]              hscale_q;
  logic [CNTW-1:0]                     row_cnt_q;
  logic signed [LANEW-1:0]             lane_q [PARALLELISM];
  logic signed [LANEW-1:0]             lane_d [PARALLELISM];
  logic                                lane_vld_q;
  logic signed [ENERGY_TOTAL_BIT-1:0]  acc_q, acc_d;
  logic                                ovf_q, ovf_d;

  logic                                beat, start_ok, last_beat;
  logic [IDXW-1:0]                     row_idx;
  logic signed [TERMW-1:0]             h_ext, h_scl, j_ext, term;
  logic signed [LANEW-1:0]             row_sum;
  logic signed [SUMW-1:0]              sum_w;
  logic [HIW-1:0]                      sum_hi;

  assign weight_ready_o = (state_q == S_RUN);
  assign energy_valid_o = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign energy_o       = acc_q;
  assign overflow_o     = ovf_q;
  assign beat           = weight_valid_i & weight_ready_o;
  assign start_ok       = start_i & (state_q == S_IDLE);
  assign last_beat      = (row_cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (beat && last_beat) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (energy_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Row values for the beat on the bus. Lane l carries row row_cnt_q+l; its
  // diagonal column is replaced by the scaled bias.
  always_comb begin
    row_idx = '0;
    h_ext   = '0;
    h_scl   = '0;
    j_ext   = '0;
    term    = '0;
    row_sum = '0;
    for (int l = 0; l < PARALLELISM; l++) begin
      lane_d[l] = '0;
    end
    for (int l = 0; l < PARALLELISM; l++) begin
      row_idx = IDXW'(row_cnt_q) + IDXW'(l);
      h_ext   = TERMW'($signed(hbias_i[l*BITH +: BITH]));
      h_scl   = h_ext;
      // Only a one-hot scale selects a shift; anything else means x1.
      if ($onehot(hscale_q)) begin
        for (int k = 0; k < SCALING_BIT; k++) begin
          if (hscale_q[k]) h_scl = h_ext <<< k;
        end
      end
      row_sum = '0;
      for (int j = 0; j < DATASPIN; j++) begin
        if (IDXW'(j) == row_idx) begin
          term = h_scl;
        end else begin
          j_ext = TERMW'($signed(weight_i[(l*DATASPIN+j)*BITJ +: BITJ]));
          term  = spin_q[j] ? j_ext : -j_ext;
        end
        row_sum = row_sum + LANEW'(term);
      end
      lane_d[l] = spin_q[row_idx] ? row_sum : -row_sum;
    end
  end

  // Lanes are folded in one after another so that every individual addition
  // is checked for signed overflow of the ENERGY_TOTAL_BIT result.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    sum_w  = '0;
    sum_hi = '0;
    if (lane_vld_q) begin
      for (int l = 0; l < PARALLELISM; l++) begin
        sum_w  = SUMW'(acc_d) + SUMW'(lane_q[l]);
        sum_hi = sum_w[SUMW-1:ENERGY_TOTAL_BIT-1];
        if (!((&sum_hi) || (sum_hi == '0))) ovf_d = 1'b1;
        acc_d  = sum_w[ENERGY_TOTAL_BIT-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      spin_q     <= '0;
      hscale_q   <= '0;
      row_cnt_q  <= '0;
      lane_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      for (int l = 0; l < PARALLELISM; l++) lane_q[l] <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        spin_q     <= spin_i;
        hscale_q   <= hscaling_i;
        row_cnt_q  <= '0;
        lane_vld_q <= 1'b0;
        acc_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        acc_q      <= acc_d;
        ovf_q      <= ovf_d;
        lane_vld_q <= beat;
        if (beat) begin
          for (int l = 0; l < PARALLELISM; l++) lane_q[l] <= lane_d[l];
          row_cnt_q <= row_cnt_q + STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_partial_energy_acc.sv
// tb/tb_partial_energy_acc.sv - randomized self-checking bench for partial_energy_acc
module tb_partial_energy_acc;
  localparam int DS  = 4;
  localparam int PAR = 2;
  localparam int BJ  = 4;
  localparam int BH  = 4;
  localparam int SB  = 5;
  localparam int NB  = DS / PAR;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic                   start_i;
  logic [DS-1:0]          spin_i;
  logic [SB-1:0]          hscaling_i;
  logic                   weight_valid_i;
  logic [PAR*DS*BJ-1:0]   weight_i;
  logic [PAR*BH-1:0]      hbias_i;
  logic                   energy_ready_i;

  logic                   wr_a, ev_a, busy_a, ov_a;
  logic [31:0]            e_a;
  logic                   wr_b, ev_b, busy_b, ov_b;
  logic [5:0]             e_b;

  int n_chk  = 0;
  int n_pass = 0;
  int jm [DS][DS];
  int hv [DS];

  always #5 clk = ~clk;

  partial_energy_acc #(.BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .DATASPIN(DS),
                       .PARALLELISM(PAR), .ENERGY_TOTAL_BIT(32)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .spin_i(spin_i),
    .hscaling_i(hscaling_i), .weight_valid_i(weight_valid_i), .weight_ready_o(wr_a),
    .weight_i(weight_i), .hbias_i(hbias_i), .energy_valid_o(ev_a),
    .energy_ready_i(energy_ready_i), .energy_o(e_a), .busy_o(busy_a), .overflow_o(ov_a));

  partial_energy_acc #(.BITJ(BJ), .BITH(BH), .SCALING_BIT(SB), .DATASPIN(DS),
                       .PARALLELISM(PAR), .ENERGY_TOTAL_BIT(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .spin_i(spin_i),
    .hscaling_i(hscaling_i), .weight_valid_i(weight_valid_i), .weight_ready_o(wr_b),
    .weight_i(weight_i), .hbias_i(hbias_i), .energy_valid_o(ev_b),
    .energy_ready_i(energy_ready_i), .energy_o(e_b), .busy_o(busy_b), .overflow_o(ov_b));

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference energy straight from the row formula, accumulated in row order
  // into a w-bit two's complement register with sticky overflow.
  task automatic model(input logic [DS-1:0] sp, input logic [SB-1:0] hs, input int w,
                       output longint e, output bit ov);
    longint acc, mult, s, rv, lo, hi, m;
    acc  = 0;
    mult = 1;
    ov   = 0;
    if ($countones(hs) == 1)
      for (int k = 0; k < SB; k++) if (hs[k]) mult = longint'(1) << k;
    lo = -(longint'(1) << (w - 1));
    hi = -lo - 1;
    m  = longint'(1) << w;
    for (int r = 0; r < DS; r++) begin
      s = 0;
      for (int j = 0; j < DS; j++) begin
        if (j == r) s += hv[r] * mult;
        else        s += sp[j] ? jm[r][j] : -jm[r][j];
      end
      rv  = sp[r] ? s : -s;
      acc = acc + rv;
      if (acc < lo || acc > hi) begin
        ov  = 1;
        acc = ((acc - lo) % m + m) % m + lo;
      end
    end
    e = acc;
  endtask

  task automatic set_beat(input int b);
    for (int l = 0; l < PAR; l++) begin
      for (int j = 0; j < DS; j++) weight_i[(l*DS+j)*BJ +: BJ] = BJ'(jm[b*PAR+l][j]);
      hbias_i[l*BH +: BH] = BH'(hv[b*PAR+l]);
    end
  endtask

  task automatic fill(input int jv, input int hval);
    for (int r = 0; r < DS; r++) begin
      hv[r] = hval;
      for (int j = 0; j < DS; j++) jm[r][j] = jv;
    end
  endtask

  task automatic run_pass(input logic [DS-1:0] sp, input logic [SB-1:0] hs, input bit toggle,
                          input int hold, input bit poke, input string tag);
    longint e32, e6;
    bit     o32, o6;
    int     b, cyc;
    logic   take;
    model(sp, hs, 32, e32, o32);
    model(sp, hs, 6, e6, o6);
    @(negedge clk);
    spin_i = sp; hscaling_i = hs; start_i = 1'b1; weight_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    spin_i = DS'($urandom);
    hscaling_i = SB'($urandom);
    check({tag, ":busy_after_start"}, busy_a, 1);
    check({tag, ":ovf_cleared"}, ov_b, 0);
    check({tag, ":acc_cleared"}, e_a, 0);
    b = 0; cyc = 0;
    while (b < NB && cyc < 50) begin
      @(negedge clk);
      set_beat(b);
      weight_valid_i = toggle ? (cyc % 2 == 1) : 1'b1;
      take = weight_valid_i & wr_a;
      @(posedge clk); #1;
      cyc++;
      if (take) b++;
    end
    check({tag, ":beats"}, b, NB);
    weight_valid_i = 1'($urandom);
    while (!ev_a && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":valid_seen"}, ev_a, 1);
    if (!toggle) check({tag, ":latency"}, cyc, NB + 1);
    check({tag, ":energy32"}, longint'($signed(e_a)), e32);
    check({tag, ":energy6"}, longint'($signed(e_b)), e6);
    check({tag, ":ovf32"}, ov_a, o32);
    check({tag, ":ovf6"}, ov_b, o6);
    check({tag, ":valid6"}, ev_b, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      energy_ready_i = 1'b0;
      start_i = poke;
      @(posedge clk); #1;
      start_i = 1'b0;
      check({tag, ":hold_valid"}, ev_a, 1);
      check({tag, ":hold_energy"}, longint'($signed(e_a)), e32);
      check({tag, ":hold_ovf6"}, ov_b, o6);
      check({tag, ":hold_ready"}, wr_a, 0);
    end
    @(negedge clk);
    energy_ready_i = 1'b1;
    @(posedge clk); #1;
    energy_ready_i = 1'b0;
    weight_valid_i = 1'b0;
    check({tag, ":valid_dropped"}, ev_a, 0);
    check({tag, ":idle"}, busy_a, 0);
    check({tag, ":energy_held"}, longint'($signed(e_a)), e32);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; spin_i = '0; hscaling_i = '0;
    weight_valid_i = 1'b0; weight_i = '0; hbias_i = '0; energy_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:ready", wr_a, 0);
    check("rst:valid", ev_a, 0);
    check("rst:energy", e_a, 0);
    check("rst:busy", busy_a, 0);
    check("rst:ovf", ov_a, 0);
    @(negedge clk);
    rst_i = 1'b0;

    fill(1, 0);
    run_pass(4'b1111, 5'd1, 0, 0, 0, "all_ones");
    fill(1, 2);
    run_pass(4'b0000, 5'd4, 0, 0, 0, "scale4");
    run_pass(4'b0000, 5'd3, 0, 0, 0, "scale3");
    fill(-8, 0);
    run_pass(4'b0001, 5'd1, 0, 0, 0, "neg8");
    fill(1, 0);
    run_pass(4'b1111, 5'd1, 1, 5, 1, "backpressure");
    fill(7, 0);
    run_pass(4'b1111, 5'd1, 0, 0, 0, "overflow");
    fill(1, 0);
    run_pass(4'b1111, 5'd1, 0, 0, 0, "ovf_clear");

    // Reset in the middle of a pass.
    @(negedge clk);
    spin_i = 4'b1111; hscaling_i = 5'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    set_beat(0);
    weight_valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_i = 1'b1;
    weight_valid_i = 1'b0;
    @(posedge clk); #1;
    check("midrst:busy", busy_a, 0);
    check("midrst:ready", wr_a, 0);
    check("midrst:valid", ev_a, 0);
    check("midrst:energy", e_a, 0);
    check("midrst:ovf", ov_a, 0);
    @(negedge clk);
    rst_i = 1'b0;
    run_pass(4'b1111, 5'd1, 0, 0, 0, "after_rst");

    for (int t = 0; t < 24; t++) begin
      for (int r = 0; r < DS; r++) begin
        hv[r] = int'($urandom_range(0, 15)) - 8;
        for (int j = 0; j < DS; j++) jm[r][j] = int'($urandom_range(0, 15)) - 8;
      end
      run_pass(DS'($urandom),
               ($urandom_range(0, 1) == 1) ? SB'(1 << $urandom_range(0, SB - 1)) : SB'($urandom),
               1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/partial_energy_acc.md
# partial_energy_acc

Sequential, parametrised Ising energy accumulator: consumes the coupling matrix row-by-row, PARALLELISM rows per beat, under a valid/ready stream, and returns the total energy of a latched spin configuration. Each row contributes its spin times the sum of its local field and scaled bias. It sits between the weight-memory streamer and the annealer control, replacing per-spin combinational energy evaluation with one pipelined pass over all DATASPIN rows.

## Interface
- BITJ, 4, signed coupling width
- BITH, 4, signed bias width
- SCALING_BIT, 5, bias scaling factor width (one-hot power of two)
- DATASPIN, 256, number of spins/rows; must be a multiple of PARALLELISM
- PARALLELISM, 4, rows processed per accepted beat (lanes)
- ENERGY_TOTAL_BIT, 32, accumulator/output width, two's complement

- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  pulse; latches spin_i/hscaling_i and begins a pass (IDLE only)
- spin_i  in  DATASPIN  spin vector; bit 1 = +1, bit 0 = -1
- hscaling_i  in  SCALING_BIT  bias scale
- weight_valid_i  in  1  beat valid
- weight_ready_o  out  1  beat ready
- weight_i  in  PARALLELISM*DATASPIN*BITJ  lane l, column j at bits [(l*DATASPIN+j)*BITJ +: BITJ]; lane l is row row_cnt+l
- hbias_i  in  PARALLELISM*BITH  lane l bias at [l*BITH +: BITH]
- energy_valid_o  out  1  result valid
- energy_ready_i  in  1  result accepted
- energy_o  out  ENERGY_TOTAL_BIT  total energy
- busy_o  out  1  high in any state except IDLE
- overflow_o  out  1  sticky accumulator overflow flag

## Operation
- Per lane, row r: term_j = σ_j·J_rj for j≠r; at j=r the term is h_r·scale instead. Row value = σ_r·Σ_j term_j. Energy = Σ over all rows.
- Scale: if exactly one bit k of hscaling_i is set, h is shifted left by k; any other value (0, multiple bits) uses scale 1.
- Widths: bias product MULTBIT = BITH+SCALING_BIT-1. Term width = max(BITJ, MULTBIT)+1, so negating the most negative value is exact. Lane sum width = term width + clog2(DATASPIN), with no loss.
- Accumulator: ENERGY_TOTAL_BIT wide, wraps two's complement. overflow_o is set on any signed overflow of an addition and cleared on start.
- FSM:
  - IDLE: weight_ready_o=0. start_i latches spin and scale, clears the accumulator, row_cnt and overflow, then goes to RUN.
  - RUN: weight_ready_o=1. Each handshake computes PARALLELISM row values into the lane register and sets row_cnt += PARALLELISM. The beat with row_cnt+PARALLELISM==DATASPIN goes to DRAIN.
  - DRAIN: one cycle; the last lane register is added into the accumulator; goes to DONE.
  - DONE: energy_valid_o=1. On energy_ready_i, goes to IDLE.
- start_i outside IDLE is ignored. Latched spin and scale are stable for the whole pass, regardless of later input changes.
- The lane register feeds the accumulator only when it holds a beat that has not yet been accumulated; bubbles add nothing.

## Timing
- Reset: state IDLE. weight_ready_o=0, energy_valid_o=0, energy_o=0, busy_o=0, overflow_o=0. Accumulator, row_cnt and lane register are cleared.
- Reset mid-pass aborts immediately; no partial result is emitted.
- Beat accepted at edge E: lane register updates at E, accumulator updates at E+1.
- Back-to-back beats are accepted with no bubbles.
- With start at edge S and valid held high: beats are accepted at S+1..S+N (N=DATASPIN/PARALLELISM), DONE follows edge S+N+1, and energy_valid_o is high in the cycle after.
- In DONE, energy_o and overflow_o are stable while energy_valid_o=1 && energy_ready_i=0.
- energy_o holds its value after the handshake until the next start.
- weight_ready_o does not depend combinationally on weight_valid_i.

## Test plan
Config for all scenarios: DATASPIN=4, PARALLELISM=2, BITJ=4, BITH=4, ENERGY_TOTAL_BIT=32 unless noted.
- All spins 1, all J=1, h=0, scale=1, valid held high -> 2 beats accepted. Energy_o=12, energy_valid_o asserted 3 cycles after start edge +1, overflow_o=0.
- Spins 0000, J=1, h=2, hscaling=4 -> each row -(-3+8)=-5, energy_o=-20. Repeat with hscaling=3 -> treated as scale 1, each row -(-3+2)=1, energy_o=4.
- All J=-8, spins 0001, h=0 -> row0 +24, rows1-3 -8 each, energy_o=0. Checks exact negation of -8.
- Backpressure: weight_valid_i toggled every other cycle; energy_ready_i low for 5 cycles in DONE; start_i pulsed in DONE -> result 12 unchanged and stable, start ignored, weight_ready_o=0 in DONE.
- Overflow: ENERGY_TOTAL_BIT=6, all J=7, spins all 1 -> rows 21 each, energy_o=20 (84 mod 64), overflow_o=1. The next start clears overflow_o.
- rst_i asserted after first beat -> all outputs 0 next cycle, busy_o=0. A fresh start with scenario 1 stimulus returns 12.
